// File: rtl/mips8_pkg.sv
// Shared command codes and FSM state encoding for the MIPS-8 boot sequencer.
package mips8_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_HALT = 8'h03;
  localparam logic [7:0] CMD_STEP = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/mips8_pad_sync.sv
// Multi-flop synchronizer for the asynchronous pad strobe, command flag and data byte,
// followed by a rising-edge detect on the strobe that yields a one-cycle event.
module mips8_pad_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_stb,
  input  logic       i_cmd,
  input  logic [7:0] i_data,
  output logic       o_evt,
  output logic       o_cmd,
  output logic [7:0] o_data
);

  // Data and command travel alongside the strobe so they are stable when the edge is seen.
  logic [9:0] r_sync [SYNC_STAGES];
  logic       r_stb_prev;
  logic [9:0] w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_stb_prev <= 1'b0;
    end else begin
      r_sync[0] <= {i_stb, i_cmd, i_data};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_stb_prev <= r_sync[SYNC_STAGES-1][9];
    end
  end

  assign w_last = r_sync[SYNC_STAGES-1];
  assign o_evt  = w_last[9] & ~r_stb_prev;
  assign o_cmd  = w_last[8];
  assign o_data = w_last[7:0];

endmodule

// File: rtl/mips8_boot_ctrl.sv
// Boot sequencer: assembles pad bytes into imem words, then runs/halts/steps the core.
// Optional MIPS8_BOOT_CSUM_EN adds ld_csum_o, an XOR of all data bytes seen in LOAD.
module mips8_boot_ctrl
  import mips8_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [7:0]         pad_data_i,
  input  logic               pad_stb_i,
  input  logic               pad_cmd_i,
  input  logic               core_halt_i,
  output logic               core_rst_o,
  output logic               core_en_o,
  output logic               imem_we_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic [INSTR_W-1:0] imem_wdata_o,
  output logic [1:0]         state_o,
`ifdef MIPS8_BOOT_CSUM_EN
  output logic [7:0]         ld_csum_o,
`endif
  output logic               ld_ovf_o
);

  localparam int NB = INSTR_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(NB - 1);

  logic              w_evt, w_cmd;
  logic [7:0]        w_data;
  logic              w_is_cmd, w_is_dat;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [INSTR_W-1:0] r_buf, w_buf_nxt, w_word;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_we, w_we_nxt;
  logic [INSTR_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              r_core_rst, w_core_rst_nxt;
  logic              r_core_en, w_core_en_nxt;
  logic              w_step;
`ifdef MIPS8_BOOT_CSUM_EN
  logic [7:0]        r_csum, w_csum_nxt;
`endif

  mips8_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pad_sync (
    .i_clk  (wb_clk_i),
    .i_rst  (wb_rst_i),
    .i_stb  (pad_stb_i),
    .i_cmd  (pad_cmd_i),
    .i_data (pad_data_i),
    .o_evt  (w_evt),
    .o_cmd  (w_cmd),
    .o_data (w_data)
  );

  assign w_is_cmd = w_evt & w_cmd;
  assign w_is_dat = w_evt & ~w_cmd;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_ovf      <= 1'b0;
      r_core_rst <= 1'b1;
      r_core_en  <= 1'b0;
`ifdef MIPS8_BOOT_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_buf      <= w_buf_nxt;
      r_addr     <= w_addr_nxt;
      r_we       <= w_we_nxt;
      r_wdata    <= w_wdata_nxt;
      r_ovf      <= w_ovf_nxt;
      r_core_rst <= w_core_rst_nxt;
      r_core_en  <= w_core_en_nxt;
`ifdef MIPS8_BOOT_CSUM_EN
      r_csum     <= w_csum_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_buf_nxt      = r_buf;
    w_addr_nxt     = r_addr;
    w_we_nxt       = 1'b0;
    w_wdata_nxt    = r_wdata;
    w_ovf_nxt      = r_ovf;
    w_core_rst_nxt = r_core_rst;
    w_step         = 1'b0;
    w_word         = r_buf;
    w_word[8*int'(r_cnt) +: 8] = w_data;
`ifdef MIPS8_BOOT_CSUM_EN
    w_csum_nxt     = r_csum;
`endif

    // Address advances the cycle after its write, so imem_addr_o matches the pulse.
    if (r_we && !r_ovf) w_addr_nxt = r_addr + ADDR_W'(1);

    case (r_state)
      ST_IDLE: begin
        if (w_is_cmd && w_data == CMD_RUN) begin
          w_state_nxt    = ST_RUN;
          w_core_rst_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        if (w_is_dat) begin
`ifdef MIPS8_BOOT_CSUM_EN
          w_csum_nxt = r_csum ^ w_data;
`endif
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            if (!r_ovf) begin
              w_we_nxt    = 1'b1;
              w_wdata_nxt = w_word;
              if (r_addr == ADDR_MAX) w_ovf_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
            w_buf_nxt = w_word;
          end
        end else if (w_is_cmd && w_data == CMD_RUN) begin
          w_state_nxt    = ST_RUN;
          w_cnt_nxt      = '0;
          w_core_rst_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (core_halt_i || (w_is_cmd && w_data == CMD_HALT)) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (w_is_cmd && w_data == CMD_RUN)  w_state_nxt = ST_RUN;
        if (w_is_cmd && w_data == CMD_STEP) w_step      = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // LOAD restarts the image from any state and overrides everything above.
    if (w_is_cmd && w_data == CMD_LOAD) begin
      w_state_nxt    = ST_LOAD;
      w_core_rst_nxt = 1'b1;
      w_addr_nxt     = '0;
      w_cnt_nxt      = '0;
      w_ovf_nxt      = 1'b0;
      w_we_nxt       = 1'b0;
      w_step         = 1'b0;
`ifdef MIPS8_BOOT_CSUM_EN
      w_csum_nxt     = '0;
`endif
    end

    w_core_en_nxt = (w_state_nxt == ST_RUN) | w_step;
  end

  assign core_rst_o   = r_core_rst;
  assign core_en_o    = r_core_en;
  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_addr;
  assign imem_wdata_o = r_wdata;
  assign state_o      = r_state;
  assign ld_ovf_o     = r_ovf;
`ifdef MIPS8_BOOT_CSUM_EN
  assign ld_csum_o    = r_csum;
`endif

endmodule
